ula_muldiv: RTL and testbench

//  Iterative RV32M multiply/divide unit and companion to the combinational ULA in the execute stage.
//  It accepts the same operand pair (data1_in/data2_in) plus an M-extension funct3 code.
//  It computes the result over a fixed number of cycles and returns it with a one-cycle done pulse.
//  The control unit stalls the pipeline while busy_out=1.

---
 rtl/ula_muldiv_pkg.sv | 23 ++
 rtl/ula_muldiv_step.sv | 39 +++
 rtl/ula_muldiv.sv | 134 +++++++++++++
 tb/tb_ula_muldiv.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ula_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes and FSM state encodings.
package ula_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/ula_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
// {hi, lo} is the 2*XLEN accumulator; m is the multiplicand or divisor magnitude.
module ula_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    hi_next = hi;
    lo_next = lo;
    sum     = {1'b0, hi} + ({1'b0, m} & {(XLEN+1){lo[0]}});
    shifted = {hi, lo[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, m};
    if (is_div) begin
      // Partial remainder is always < m, so a successful subtract fits in XLEN bits.
      if (!diff[XLEN+1]) begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ula_muldiv.sv
// Iterative RV32M multiply/divide unit: magnitude datapath over XLEN cycles,
// then sign fix-up and result selection, with a one-cycle done pulse.
module ula_muldiv
  import ula_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_in,
  input  logic [2:0]      select_md,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] data_out,
  output logic            div_zero
);

  md_state_e       state, state_next;
  md_op_e          op_in, op_q;
  logic            is_div_q, neg_q, dz_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, dividend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] hi_step, lo_step;

  logic            a_signed, b_signed, a_neg, b_neg, is_div_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] q_fix, r_fix, result_fix;

  always_comb begin
    op_in     = md_op_e'(select_md);
    is_div_in = select_md[2];
    a_signed  = (op_in == MD_MULH) || (op_in == MD_MULHSU) || (op_in == MD_DIV) || (op_in == MD_REM);
    b_signed  = (op_in == MD_MULH) || (op_in == MD_DIV) || (op_in == MD_REM);
    a_neg     = a_signed & data1_in[XLEN-1];
    b_neg     = b_signed & data2_in[XLEN-1];
    a_mag     = a_neg ? -data1_in : data1_in;
    b_mag     = b_neg ? -data2_in : data2_in;
  end

  ula_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div_q),
    .hi      (hi_q),
    .lo      (lo_q),
    .m       (m_q),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state)
      ST_IDLE: if (start_in) state_next = ST_CALC;
      ST_CALC: begin
        busy_out = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) state_next = ST_FIX;
      end
      ST_FIX: begin
        busy_out   = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        busy_out   = 1'b1;
        done_out   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A zero divisor bypasses sign fix-up: the magnitude quotient is already all ones.
  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    q_fix    = neg_q ? -lo_q : lo_q;
    r_fix    = neg_q ? -hi_q : hi_q;
    case (op_q)
      MD_MUL:                       result_fix = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              result_fix = dz_q ? '1 : q_fix;
      default:                      result_fix = dz_q ? dividend_q : r_fix;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= MD_MUL;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
      data_out   <= '0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_in) begin
          op_q       <= op_in;
          is_div_q   <= is_div_in;
          neg_q      <= ((op_in == MD_REM) || (op_in == MD_REMU)) ? a_neg : (a_neg ^ b_neg);
          dz_q       <= is_div_in && (data2_in == '0);
          hi_q       <= '0;
          lo_q       <= is_div_in ? a_mag : b_mag;
          m_q        <= is_div_in ? b_mag : a_mag;
          dividend_q <= data1_in;
          cnt_q      <= '0;
        end
        ST_CALC: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q + 1'b1;
        end
        ST_FIX: begin
          data_out <= result_fix;
          div_zero <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv.sv
// Directed-vector bench for ula_muldiv: results, latency, busy window,
// ignored mid-operation starts and asynchronous reset abort.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic [2:0]  select_md = 3'b000;
  logic [31:0] data1_in = '0;
  logic [31:0] data2_in = '0;
  logic        busy_out, done_out, div_zero;
  logic [31:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  ula_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .select_md (select_md),
    .data1_in  (data1_in),
    .data2_in  (data2_in),
    .busy_out  (busy_out),
    .done_out  (done_out),
    .data_out  (data_out),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge, scramble operands after accept, then track busy/done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input logic exp_dz);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    @(negedge clk);
    select_md = op; data1_in = a; data2_in = b; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0; data1_in = $urandom; data2_in = $urandom; select_md = 3'($urandom);
    for (int i = 1; i <= 40 && !seen; i++) begin
      if (busy_out) busy_cnt++;
      if (done_out) begin
        seen = 1;
        cyc = i;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_lat"}, 32'(cyc), 32'd34);
    check({tag, "_busy"}, 32'(busy_cnt), 32'd34);
    check({tag, "_data"}, data_out, exp_d);
    check({tag, "_dz"}, 32'(div_zero), 32'(exp_dz));
    @(negedge clk);
    check({tag, "_post"}, {30'd0, busy_out, done_out}, 32'd0);
    check({tag, "_hold"}, data_out, exp_d);
  endtask

  initial begin
    int dones;
    int first;
    logic [31:0] first_data;

    #2;
    check("rst_data", data_out, 32'd0);
    check("rst_ctl", {29'd0, busy_out, done_out, div_zero}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("mul",     3'b000, 32'd7,        32'd6,        32'd42,       1'b0);
    run_op("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0);
    run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    run_op("div_nn",  3'b100, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'd6,        1'b0);
    run_op("rem_nn",  3'b110, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0);
    run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
    run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0);
    run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("div_z",   3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);

    // Start pulse during CALC must be ignored.
    @(negedge clk);
    select_md = 3'b000; data1_in = 32'd7; data2_in = 32'd6; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    dones = 0; first = 0; first_data = '0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 5) begin
        select_md = 3'b101; data1_in = 32'd1000; data2_in = 32'd3; start_in = 1'b1;
      end else begin
        start_in = 1'b0;
      end
      if (done_out) begin
        dones++;
        if (first == 0) begin
          first = i;
          first_data = data_out;
        end
      end
      @(negedge clk);
    end
    check("ign_dones", 32'(dones), 32'd1);
    check("ign_lat", 32'(first), 32'd34);
    check("ign_data", first_data, 32'd42);

    // Leave div_zero and data_out non-zero before the reset abort.
    run_op("rem_z", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
    @(negedge clk);
    select_md = 3'b101; data1_in = 32'd100; data2_in = 32'd7; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_data", data_out, 32'd0);
    check("arst_ctl", {29'd0, busy_out, done_out, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_out || busy_out) dones++;
      @(negedge clk);
    end
    check("arst_quiet", 32'(dones), 32'd0);
    run_op("after_rst", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
